uart_hex_decoder: RTL and testbench
===================================

Name: uart_hex_decoder

Overview:
- Inverse of the byte-to-hex echo path: consumes ASCII characters from the uart_rx valid/data outputs and assembles each pair of hex digits (high nibble first) into one binary byte.
- Sits between uart_rx and any command/register logic in top.
- Delivers bytes through a valid/ready handshake with a one-entry holding register.
- Flags malformed input and input that arrives while the holding register is full.

Parameters:
- ACCEPT_LOWER, 1: when 1, 'a'..'f' are digits; when 0, they are invalid characters.
- TIMEOUT_CYCLES, 12_000_000: maximum number of CLK cycles a pending high nibble waits for its low nibble (1 s at 12 MHz); 0 disables the timeout. Width of the counter is $clog2(TIMEOUT_CYCLES+1).

Ports:
- CLK  in  1  system clock (12 MHz on board)
- RST  in  1  asynchronous, active-high reset
- rx_valid  in  1  single-cycle strobe from uart_rx, a character is available
- rx_data  in  8  character from uart_rx, sampled only when rx_valid=1
- byte_valid  out  1  assembled byte available in byte_data
- byte_data  out  8  assembled byte, stable while byte_valid=1
- byte_ready  in  1  consumer accepts the byte; transfer occurs when byte_valid & byte_ready on a CLK edge
- err_char  out  1  one-cycle pulse: invalid character received
- err_overrun  out  1  one-cycle pulse: character dropped because the holding register was full
- err_timeout  out  1  one-cycle pulse: pending high nibble discarded by timeout
- busy  out  1  high nibble pending (state WAIT_LO)

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RST).
- Reset values:
  - byte_valid=0, byte_data=0x00, err_*=0, busy=0.
  - State WAIT_HI, timeout counter 0.
- Character classes:
  - DIGIT: '0'-'9', 'A'-'F', and 'a'-'f' if ACCEPT_LOWER=1.
  - SEP: 0x20, 0x0D, 0x0A, 0x09, ','.
  - INVALID: everything else.
- States:
  - WAIT_HI:
    - DIGIT: latch the nibble into hi_reg, go to WAIT_LO, clear the timeout counter.
    - SEP: ignored.
    - INVALID: err_char pulse, stay.
  - WAIT_LO:
    - DIGIT: form {hi_reg, nibble}. If the holding register is free or being drained this cycle, load byte_data, set byte_valid, go to WAIT_HI. Otherwise err_overrun pulse, discard both nibbles, go to WAIT_HI.
    - SEP: discard hi_reg silently (resync), go to WAIT_HI.
    - INVALID: err_char pulse, discard hi_reg, go to WAIT_HI.
    - Timeout: the counter increments every cycle without rx_valid. When it reaches TIMEOUT_CYCLES (if nonzero), err_timeout pulse, go to WAIT_HI. If rx_valid arrives in that same cycle, the character wins and no timeout fires.
- Holding register:
  - byte_valid stays high until a handshake.
  - A handshake plus a new completed byte in the same cycle loads the new byte and keeps byte_valid=1 (no bubble, no overrun).
  - byte_data must not change while byte_valid=1 without a handshake.
- Latency: byte_valid rises on the CLK edge after the rx_valid cycle carrying the low digit (1 cycle).
- rx_valid during a reset assertion is ignored.
- Reset mid-byte discards hi_reg and any held byte.
- err_* pulses are mutually exclusive; each is exactly one cycle.
- busy = (state == WAIT_LO).

Optional Feature:
- Macro: UART_HEX_DECODER_ERR_CNT_EN.
- Defined:
  - Adds output err_count [7:0]: saturating count (stops at 0xFF) of all err_char, err_overrun and err_timeout pulses.
  - Cleared by RST and by input err_clr (1-bit, synchronous). If err_clr and an error pulse occur in the same cycle, the result is 0.
- Undefined: the err_count and err_clr ports do not exist; no counter logic.

Decomposition:
- Shared package/include uart_hex_pkg: state encodings WAIT_HI/WAIT_LO, SEP character constants, CLK_HZ=12_000_000.
- Sub-module ascii_to_nibble (combinational):
  - Inputs: ch[7:0] and the ACCEPT_LOWER parameter.
  - Outputs: nib[3:0], is_digit, is_sep.
  - Exact inverse of nibble_to_ascii for uppercase digits.
- All sequential logic stays in uart_hex_decoder.

Test Plan:
- Send "4", "1" with byte_ready=1 -> byte_valid for 1 cycle, byte_data=0x41, no err pulses.
- Send "f", "F" with ACCEPT_LOWER=1 -> 0xFF. With ACCEPT_LOWER=0 -> err_char on 'f', then 'F' held pending (busy=1).
- byte_ready=0, send "12" then "34" -> byte_data stays 0x12, err_overrun pulses on '4'. Raise ready -> 0x12 accepted; next "56" -> 0x56.
- Send "7", space, "A", "B" -> no byte from '7' and no error; then 0xAB.
- Send "9", wait TIMEOUT_CYCLES (use 100 in bench) -> err_timeout at cycle 100, busy drops. Then "0","1" -> 0x01.
- Send "G", then assert RST mid-pair after "3" -> err_char pulse for 'G'; after reset all outputs 0, busy=0. With UART_HEX_DECODER_ERR_CNT_EN, err_count=1 before the reset and 0 after.

Source files
------------

// File: rtl/uart_hex_pkg.sv
// Shared types and constants for the ASCII-hex to byte decoder.
package uart_hex_pkg;

  localparam int unsigned CLK_HZ = 12_000_000;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  localparam logic [7:0] SEP_SPACE = 8'h20;
  localparam logic [7:0] SEP_CR    = 8'h0D;
  localparam logic [7:0] SEP_LF    = 8'h0A;
  localparam logic [7:0] SEP_TAB   = 8'h09;
  localparam logic [7:0] SEP_COMMA = 8'h2C;

endpackage

// File: rtl/ascii_to_nibble.sv
// Combinational ASCII classifier: hex digit value, digit flag and separator flag.
module ascii_to_nibble
  import uart_hex_pkg::*;
#(
  parameter bit ACCEPT_LOWER = 1'b1
) (
  input  logic [7:0] ch,
  output logic [3:0] nib,
  output logic       is_digit,
  output logic       is_sep
);

  always_comb begin
    nib      = 4'h0;
    is_digit = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_digit = 1'b1;
      nib      = 4'(ch - 8'h30);
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      is_digit = 1'b1;
      nib      = 4'(ch - 8'h37);
    end else if (ACCEPT_LOWER && ch >= 8'h61 && ch <= 8'h66) begin
      is_digit = 1'b1;
      nib      = 4'(ch - 8'h57);
    end
  end

  assign is_sep = (ch == SEP_SPACE) || (ch == SEP_CR) || (ch == SEP_LF) ||
                  (ch == SEP_TAB) || (ch == SEP_COMMA);

endmodule

// File: rtl/uart_hex_decoder.sv
// Assembles pairs of ASCII hex digits into bytes behind a one-entry valid/ready register.
// Optional saturating error counter enabled by UART_HEX_DECODER_ERR_CNT_EN.
module uart_hex_decoder
  import uart_hex_pkg::*;
#(
  parameter bit          ACCEPT_LOWER   = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  input  logic       byte_ready,
  output logic       err_char,
  output logic       err_overrun,
  output logic       err_timeout,
`ifdef UART_HEX_DECODER_ERR_CNT_EN
  input  logic       err_clr,
  output logic [7:0] err_count,
`endif
  output logic       busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic [3:0]       hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             bv_d;
  logic [7:0]       bd_d;
  logic             ec_d, eo_d, et_d;

  logic [3:0] nib;
  logic       is_digit;
  logic       is_sep;

  ascii_to_nibble #(
    .ACCEPT_LOWER(ACCEPT_LOWER)
  ) u_a2n (
    .ch      (rx_data),
    .nib     (nib),
    .is_digit(is_digit),
    .is_sep  (is_sep)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state, holding register and error pulse decode
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    bv_d    = byte_valid;
    bd_d    = byte_data;
    ec_d    = 1'b0;
    eo_d    = 1'b0;
    et_d    = 1'b0;

    if (byte_valid && byte_ready) bv_d = 1'b0;

    case (state_q)
      WAIT_HI: begin
        if (rx_valid) begin
          if (is_digit) begin
            hi_d    = nib;
            cnt_d   = '0;
            state_d = WAIT_LO;
          end else if (!is_sep) begin
            ec_d = 1'b1;
          end
        end
      end
      WAIT_LO: begin
        if (rx_valid) begin
          state_d = WAIT_HI;
          if (is_digit) begin
            // A handshake this cycle frees the register, so load without a bubble
            if (!byte_valid || byte_ready) begin
              bv_d = 1'b1;
              bd_d = {hi_q, nib};
            end else begin
              eo_d = 1'b1;
            end
          end else if (!is_sep) begin
            ec_d = 1'b1;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_inc == CNT_MAX) begin
            et_d    = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_HI;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= WAIT_HI;
      hi_q        <= 4'h0;
      cnt_q       <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'h00;
      err_char    <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      byte_valid  <= bv_d;
      byte_data   <= bd_d;
      err_char    <= ec_d;
      err_overrun <= eo_d;
      err_timeout <= et_d;
      busy        <= (state_d == WAIT_LO);
    end
  end

`ifdef UART_HEX_DECODER_ERR_CNT_EN
  // Clear has priority over a simultaneous error
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_count <= 8'h00;
    end else if (err_clr) begin
      err_count <= 8'h00;
    end else if ((ec_d || eo_d || et_d) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_hex_decoder.sv
// Scoreboard bench for uart_hex_decoder: expected bytes/errors queued by stimulus, checked by a monitor.
module tb_uart_hex_decoder;

  localparam int unsigned TMO = 100;
  localparam int EV_CHAR = 1;
  localparam int EV_OVR  = 2;
  localparam int EV_TMO  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       byte_ready = 1'b1;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       err_char, err_overrun, err_timeout, busy;

  logic       rx_valid_nl = 1'b0;
  logic [7:0] rx_data_nl = 8'h00;
  logic       byte_valid_nl;
  logic [7:0] byte_data_nl;
  logic       err_char_nl, err_overrun_nl, err_timeout_nl, busy_nl;

`ifdef UART_HEX_DECODER_ERR_CNT_EN
  logic       err_clr = 1'b0;
  logic [7:0] err_count;
  logic       err_clr_nl = 1'b0;
  logic [7:0] err_count_nl;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_bytes[$];
  int         exp_errs[$];

  always #5 clk = ~clk;

  uart_hex_decoder #(.ACCEPT_LOWER(1'b1), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(clk), .RST(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .err_char(err_char), .err_overrun(err_overrun), .err_timeout(err_timeout),
`ifdef UART_HEX_DECODER_ERR_CNT_EN
    .err_clr(err_clr), .err_count(err_count),
`endif
    .busy(busy)
  );

  uart_hex_decoder #(.ACCEPT_LOWER(1'b0), .TIMEOUT_CYCLES(TMO)) dut_nl (
    .CLK(clk), .RST(rst), .rx_valid(rx_valid_nl), .rx_data(rx_data_nl),
    .byte_valid(byte_valid_nl), .byte_data(byte_data_nl), .byte_ready(1'b1),
    .err_char(err_char_nl), .err_overrun(err_overrun_nl), .err_timeout(err_timeout_nl),
`ifdef UART_HEX_DECODER_ERR_CNT_EN
    .err_clr(err_clr_nl), .err_count(err_count_nl),
`endif
    .busy(busy_nl)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic err_event(input int kind);
    if (exp_errs.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_err: got kind %0d, expected none at %0t", kind, $time);
    end else begin
      chk("err_kind", 32'(kind), 32'(exp_errs.pop_front()));
    end
  endtask

  // Monitor: compares every presented output event against the queued expectation
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (32'(err_char) + 32'(err_overrun) + 32'(err_timeout) > 1)
          chk("err_exclusive", 32'(err_char) + 32'(err_overrun) + 32'(err_timeout), 1);
        if (err_char)    err_event(EV_CHAR);
        if (err_overrun) err_event(EV_OVR);
        if (err_timeout) err_event(EV_TMO);
        if (byte_valid && byte_ready) begin
          if (exp_bytes.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_byte: got 0x%0h, expected none at %0t", byte_data, $time);
          end else begin
            chk("byte_data", 32'(byte_data), 32'(exp_bytes.pop_front()));
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_nl(input logic [7:0] c);
    rx_data_nl  = c;
    rx_valid_nl = 1'b1;
    @(posedge clk);
    #1;
    rx_valid_nl = 1'b0;
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset state
    idle(3);
    chk("rst_byte_valid", 32'(byte_valid), 0);
    chk("rst_byte_data", 32'(byte_data), 0);
    chk("rst_errs", 32'({err_char, err_overrun, err_timeout}), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    idle(2);

    // "41" with ready high: one-cycle byte_valid, 1-cycle latency
    exp_bytes.push_back(8'h41);
    send("4");
    chk("busy_after_hi", 32'(busy), 1);
    send("1");
    chk("latency_valid", 32'(byte_valid), 1);
    chk("busy_after_lo", 32'(busy), 0);
    idle(1);
    chk("valid_one_cycle", 32'(byte_valid), 0);

    // Lowercase accepted here; rejected by the ACCEPT_LOWER=0 instance
    exp_bytes.push_back(8'hFF);
    send("f");
    send("F");
    idle(2);
    send_nl("f");
    chk("nl_err_char", 32'(err_char_nl), 1);
    chk("nl_busy_after_f", 32'(busy_nl), 0);
    send_nl("F");
    chk("nl_busy_after_F", 32'(busy_nl), 1);
    idle(2);

    // Overrun while holding register is full
    byte_ready = 1'b0;
    exp_bytes.push_back(8'h12);
    send("1");
    send("2");
    chk("held_valid", 32'(byte_valid), 1);
    exp_errs.push_back(EV_OVR);
    send("3");
    send("4");
    idle(1);
    chk("held_data", 32'(byte_data), 32'h12);
    chk("held_busy", 32'(busy), 0);
    byte_ready = 1'b1;
    idle(1);
    chk("drained", 32'(byte_valid), 0);
    exp_bytes.push_back(8'h56);
    send("5");
    send("6");
    idle(2);

    // Handshake and new byte in the same cycle: no bubble, no overrun
    byte_ready = 1'b0;
    exp_bytes.push_back(8'hA1);
    send("A");
    send("1");
    exp_bytes.push_back(8'hB2);
    send("B");
    byte_ready = 1'b1;
    send("2");
    chk("no_bubble_valid", 32'(byte_valid), 1);
    chk("no_bubble_data", 32'(byte_data), 32'hB2);
    idle(2);

    // Separator resyncs a pending high nibble silently
    send("7");
    send(8'h20);
    chk("sep_resync_busy", 32'(busy), 0);
    exp_bytes.push_back(8'hAB);
    send("A");
    send("B");
    idle(2);

    // Timeout on a pending high nibble
    exp_errs.push_back(EV_TMO);
    send("9");
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n = i + 1;
      if (err_timeout) break;
    end
    chk("timeout_cycle", 32'(n), TMO);
    chk("timeout_busy", 32'(busy), 0);
    exp_bytes.push_back(8'h01);
    send("0");
    send("1");
    idle(2);

`ifdef UART_HEX_DECODER_ERR_CNT_EN
    chk("err_count_before_clr", 32'(err_count), 2);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("err_count_clr", 32'(err_count), 0);
`endif

    // Invalid char, then reset mid-pair
    exp_errs.push_back(EV_CHAR);
    send("G");
    idle(1);
`ifdef UART_HEX_DECODER_ERR_CNT_EN
    chk("err_count_one", 32'(err_count), 1);
`endif
    send("3");
    chk("busy_mid_pair", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    rx_data  = "5";
    rx_valid = 1'b1;
    idle(3);
    rx_valid = 1'b0;
    rst = 1'b0;
    idle(2);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_valid", 32'(byte_valid), 0);
    chk("post_rst_data", 32'(byte_data), 0);
    chk("post_rst_errs", 32'({err_char, err_overrun, err_timeout}), 0);
`ifdef UART_HEX_DECODER_ERR_CNT_EN
    chk("post_rst_err_count", 32'(err_count), 0);
`endif

    chk("bytes_left", 32'(exp_bytes.size()), 0);
    chk("errs_left", 32'(exp_errs.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
